fb_write_arbiter: RTL and testbench

Owns the framebuffer's single write port (wr_en / wr_addr / wr_data) feeding the VGA pixel store. It shares that port round-robin between two pixel-write requesters, each using a valid/ready handshake. It also contains a built-in clear engine that fills the whole framebuffer with one colour, optionally starting at the next vertical blank. It runs in the framebuffer write clock domain, alongside the VGA block.

---
 rtl/fb_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin arbitration of two pixel writers
// plus a full-frame clear engine that can be aligned to vertical blank.
module fb_write_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 25,
  parameter int FB_DEPTH   = 307200,
  parameter int CLEAR_SYNC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              vblank,
  output logic              busy,
  output logic              clear_done,
  output logic              oob_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  generate
    if (FB_DEPTH > (2 ** ADDR_W)) begin : g_depth_chk
      $error("FB_DEPTH does not fit in ADDR_W address bits");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(FB_DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_WAIT = 2'd1,
    CLEAR      = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                vblank_prev_q;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                oob_q, oob_d;

  logic                xfer0, xfer1, xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_oob;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      vblank_prev_q <= 1'b0;
      cnt_q         <= '0;
      fill_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      oob_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      vblank_prev_q <= vblank;
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      oob_q         <= oob_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_start) state_d = (CLEAR_SYNC != 0) ? CLEAR_WAIT : CLEAR;
        else             state_d = IDLE;
      end
      CLEAR_WAIT: begin
        if (vblank && !vblank_prev_q) state_d = CLEAR;
        else                          state_d = CLEAR_WAIT;
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) state_d = IDLE;
        else                    state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Requester readys: a clear request in the same cycle blocks both writers
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE && !clear_start) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_q;
        req1_ready = ~last_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign xfer0    = req0_valid & req0_ready;
  assign xfer1    = req1_valid & req1_ready;
  assign xfer     = xfer0 | xfer1;
  assign sel_addr = xfer1 ? req1_addr : req0_addr;
  assign sel_data = xfer1 ? req1_data : req0_data;
  assign sel_oob  = ({1'b0, sel_addr} >= DEPTH_EXT);

  // Output-register and clear-counter next values; fill writes land in the same cycle the FSM is in CLEAR
  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    oob_d     = 1'b0;
    if (state_q == IDLE && clear_start) fill_d = fill_data;
    else                                fill_d = fill_q;
    if (xfer) begin
      last_d    = xfer1;
      wr_en_d   = ~sel_oob;
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      oob_d     = sel_oob;
    end else if (state_d == CLEAR) begin
      cnt_d     = (state_q == CLEAR) ? (cnt_q + ADDR_W'(1)) : '0;
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_d;
      wr_data_d = fill_d;
    end else begin
      wr_en_d   = 1'b0;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_q == CLEAR) && (state_d == IDLE);
  end

  assign busy       = busy_q;
  assign clear_done = done_q;
  assign oob_err    = oob_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench: a full-size instance for arbitration/range checks and a
// 16-pixel instance for the clear engine.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req0_valid, req1_valid, clear_start, vblank;
  logic [18:0] req0_addr, req1_addr;
  logic [24:0] req0_data, req1_data, fill_data;

  logic        b_r0v, b_r1v, s_r0v, s_r1v, s_cs;
  logic        b_r0rdy, b_r1rdy, b_busy, b_done, b_oob, b_wr_en;
  logic        s_r0rdy, s_r1rdy, s_busy, s_done, s_oob, s_wr_en;
  logic [18:0] b_wr_addr, s_wr_addr;
  logic [24:0] b_wr_data, s_wr_data;

  assign b_r0v = req0_valid & ~sel;
  assign b_r1v = req1_valid & ~sel;
  assign s_r0v = req0_valid & sel;
  assign s_r1v = req1_valid & sel;
  assign s_cs  = clear_start & sel;

  fb_write_arbiter u_big (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_ready(b_r0rdy), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(b_r1v), .req1_ready(b_r1rdy), .req1_addr(req1_addr), .req1_data(req1_data),
    .clear_start(1'b0), .fill_data(fill_data), .vblank(vblank),
    .busy(b_busy), .clear_done(b_done), .oob_err(b_oob),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  fb_write_arbiter #(.FB_DEPTH(16), .CLEAR_SYNC(1)) u_small (
    .clk(clk), .rst(rst),
    .req0_valid(s_r0v), .req0_ready(s_r0rdy), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(s_r1v), .req1_ready(s_r1rdy), .req1_addr(req1_addr), .req1_data(req1_data),
    .clear_start(s_cs), .fill_data(fill_data), .vblank(vblank),
    .busy(s_busy), .clear_done(s_done), .oob_err(s_oob),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
  );

  typedef struct {
    int          kind;   // 0 write, 1 oob_err, 2 clear_done
    logic [18:0] addr;
    logic [24:0] data;
  } exp_t;

  exp_t q_big[$];
  exp_t q_small[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int dut, input int kind, input logic [18:0] a, input logic [24:0] d);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d;
    if (dut == 0) q_big.push_back(e);
    else          q_small.push_back(e);
  endtask

  task automatic sb_pop(input int dut, input int kind, input logic [18:0] a, input logic [24:0] d);
    exp_t e;
    checks++;
    if ((dut == 0 && q_big.size() == 0) || (dut == 1 && q_small.size() == 0)) begin
      errors++;
      $display("FAIL sb_unexpected dut=%0d actual kind=%0d addr=%h data=%h required none", dut, kind, a, d);
    end else begin
      if (dut == 0) e = q_big.pop_front();
      else          e = q_small.pop_front();
      if (e.kind != kind || (kind == 0 && (e.addr !== a || e.data !== d))) begin
        errors++;
        $display("FAIL sb_item dut=%0d actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                 dut, kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every observed output event must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (b_wr_en) sb_pop(0, 0, b_wr_addr, b_wr_data);
      if (b_oob)   sb_pop(0, 1, 19'd0, 25'd0);
      if (b_done)  sb_pop(0, 2, 19'd0, 25'd0);
      if (s_wr_en) sb_pop(1, 0, s_wr_addr, s_wr_data);
      if (s_oob)   sb_pop(1, 1, 19'd0, 25'd0);
      if (s_done)  sb_pop(1, 2, 19'd0, 25'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit done_seen;
    bit hit7;
    int i0, i1;
    rst = 1'b1; sel = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; clear_start = 1'b0; vblank = 1'b0;
    req0_addr = 19'd0; req1_addr = 19'd0; req0_data = 25'd0; req1_data = 25'd0;
    fill_data = 25'd0;
    #3;
    chk("rst_wr_en",   {31'd0, b_wr_en}, 32'd0);
    chk("rst_wr_addr", {13'd0, b_wr_addr}, 32'd0);
    chk("rst_wr_data", {7'd0, b_wr_data}, 32'd0);
    chk("rst_flags",   {28'd0, s_busy, s_done, s_oob, s_wr_en}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick;

    // req0 alone: accepted same cycle, written next cycle, then idle
    req0_valid = 1'b1; req0_addr = 19'h00010; req0_data = 25'h1ABCDEF;
    push(0, 0, 19'h00010, 25'h1ABCDEF);
    #1 chk("t1_ready", {31'd0, b_r0rdy}, 32'd1);
    tick;
    req0_valid = 1'b0;
    chk("t1_wr_en", {31'd0, b_wr_en}, 32'd1);
    chk("t1_wr_addr", {13'd0, b_wr_addr}, 32'h10);
    tick;
    chk("t1_idle_after", {31'd0, b_wr_en}, 32'd0);

    // Out-of-range then last legal address on req1
    req1_valid = 1'b1; req1_addr = 19'd307200; req1_data = 25'h1234567;
    push(0, 1, 19'd0, 25'd0);
    #1 chk("oob_ready", {31'd0, b_r1rdy}, 32'd1);
    tick;
    req1_addr = 19'd307199; req1_data = 25'h0765432;
    push(0, 0, 19'd307199, 25'h0765432);
    chk("oob_pulse", {30'd0, b_oob, b_wr_en}, 32'h2);
    #1 chk("last_ready", {31'd0, b_r1rdy}, 32'd1);
    tick;
    req1_valid = 1'b0;
    chk("last_write", {30'd0, b_oob, b_wr_en}, 32'h1);
    tick;

    // Both requesters valid for six cycles: grants 0,1,0,1,0,1
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(0, 0, 19'h100 + 19'(k / 2), 25'h0A0000 + 25'(k / 2));
      else            push(0, 0, 19'h200 + 19'(k / 2), 25'h0B0000 + 25'(k / 2));
    end
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) chk("rr_stream_wr_en", {31'd0, b_wr_en}, 32'd1);
      req0_valid = 1'b1; req0_addr = 19'h100 + 19'(i0); req0_data = 25'h0A0000 + 25'(i0);
      req1_valid = 1'b1; req1_addr = 19'h200 + 19'(i1); req1_data = 25'h0B0000 + 25'(i1);
      #1;
      chk("rr_ready0", {31'd0, b_r0rdy}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", {31'd0, b_r1rdy}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (b_r0rdy) i0++;
      else if (b_r1rdy) i1++;
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_last_wr_en", {31'd0, b_wr_en}, 32'd1);
    tick;
    chk("rr_end_idle", {31'd0, b_wr_en}, 32'd0);

    // Clear on small instance, raised together with a req0 write
    sel = 1'b1;
    for (int k = 0; k < 16; k++) push(1, 0, 19'(k), 25'h0F0F0F0);
    push(1, 2, 19'd0, 25'd0);
    push(1, 0, 19'd3, 25'h0000333);
    fill_data = 25'h0F0F0F0; clear_start = 1'b1;
    req0_valid = 1'b1; req0_addr = 19'd3; req0_data = 25'h0000333;
    #1 chk("clr_start_blocks_ready", {31'd0, s_r0rdy}, 32'd0);
    tick;
    clear_start = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_done) begin
        chk("clr_done_ready", {31'd0, s_r0rdy}, 32'd1);
        chk("clr_done_busy", {31'd0, s_busy}, 32'd0);
        done_seen = 1'b1;
        break;
      end else begin
        chk("clr_ready_blocked", {31'd0, s_r0rdy}, 32'd0);
        chk("clr_busy", {31'd0, s_busy}, 32'd1);
      end
      if (i <= 3) chk("clr_no_write_before_vblank", {31'd0, s_wr_en}, 32'd0);
      vblank      = (i >= 3);
      clear_start = (i == 10);
      fill_data   = (i == 10) ? 25'h1FFFFFF : 25'h0F0F0F0;
      tick;
    end
    if (!done_seen) chk("clr_done_timeout", 32'd0, 32'd1);
    clear_start = 1'b0;
    tick;
    req0_valid = 1'b0;
    chk("clr_done_single", {31'd0, s_done}, 32'd0);
    tick;

    // Reset at fill address 7: no clear_done, then normal write latency
    vblank = 1'b0;
    tick;
    for (int k = 0; k < 8; k++) push(1, 0, 19'(k), 25'h0F0F0F0);
    fill_data = 25'h0F0F0F0; clear_start = 1'b1;
    tick;
    clear_start = 1'b0; vblank = 1'b1;
    hit7 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_wr_en && s_wr_addr == 19'd7) begin
        hit7 = 1'b1;
        break;
      end
    end
    if (!hit7) chk("mid_rst_addr7_timeout", 32'd0, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", {31'd0, s_wr_en}, 32'd0);
    chk("mid_rst_wr_addr", {13'd0, s_wr_addr}, 32'd0);
    chk("mid_rst_wr_data", {7'd0, s_wr_data}, 32'd0);
    chk("mid_rst_busy_done", {30'd0, s_busy, s_done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; vblank = 1'b0;
    tick;
    req0_valid = 1'b1; req0_addr = 19'd5; req0_data = 25'h0055555;
    push(1, 0, 19'd5, 25'h0055555);
    #1 chk("post_rst_ready", {31'd0, s_r0rdy}, 32'd1);
    tick;
    req0_valid = 1'b0;
    chk("post_rst_wr_en", {31'd0, s_wr_en}, 32'd1);
    chk("post_rst_wr_addr", {13'd0, s_wr_addr}, 32'd5);
    tick;
    chk("post_rst_idle", {30'd0, s_wr_en, s_done}, 32'd0);
    tick; tick;

    chk("sb_big_drained", q_big.size(), 32'd0);
    chk("sb_small_drained", q_small.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
